// File: rtl/mac_hash_lookup_pkg.sv
// Shared types and entry layout for the MAC hash table lookup.
// Entry layout: {valid, key[47:0], port[PORT_W-1:0]}, valid at the MSB.
// The state encoding is shared so that the bench and the RTL see the same names.
package mac_hash_lookup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int KEY_W = 48;

  // Total table entry width for a given port field width.
  function automatic int entry_w(input int port_w);
    return 1 + KEY_W + port_w;
  endfunction

  // Bit offset of the key field (sits just above the port field).
  function automatic int key_lsb(input int port_w);
    return port_w;
  endfunction

  // Bit position of the entry valid flag (MSB of the entry).
  function automatic int valid_bit(input int port_w);
    return port_w + KEY_W;
  endfunction

endpackage

// File: rtl/mac_hash_lookup_if.sv
// Request, table-read and response signals of the MAC hash lookup.
// slave is the lookup engine's view; master is the requester/RAM/consumer side.
// Field widths follow INDEX_W and PORT_W of the engine instance.
interface mac_hash_lookup_if
  import mac_hash_lookup_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int PORT_W  = 8
);

  logic                         req_valid;
  logic                         req_ready;
  logic [KEY_W-1:0]             req_key;
  logic [31:0]                  req_hash;

  logic                         tbl_rd_en;
  logic [INDEX_W-1:0]           tbl_rd_addr;
  logic [entry_w(PORT_W)-1:0]   tbl_rd_data;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic                         rsp_hit;
  logic [PORT_W-1:0]            rsp_port;
  logic [INDEX_W-1:0]           rsp_slot;

  modport slave (
    input  req_valid, req_key, req_hash, tbl_rd_data, rsp_ready,
    output req_ready, tbl_rd_en, tbl_rd_addr, rsp_valid, rsp_hit, rsp_port, rsp_slot
  );

  modport master (
    output req_valid, req_key, req_hash, tbl_rd_data, rsp_ready,
    input  req_ready, tbl_rd_en, tbl_rd_addr, rsp_valid, rsp_hit, rsp_port, rsp_slot
  );

endinterface

// File: rtl/mac_hash_lookup_stats.sv
// Saturating hit / miss / probe counters for completed lookups.
// Updates only on the response handshake cycle; latency 1 cycle to the outputs.
// Never stalls the lookup engine.
module mac_lookup_stats #(
  parameter int PCNT_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rsp_fire,
  input  logic              rsp_hit,
  input  logic [PCNT_W-1:0] probe_cnt,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_probes
);

  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic [31:0] probes_q, probes_d;
  logic [32:0] probe_sum;

  // Next counter values; every counter sticks at all-ones instead of wrapping.
  always_comb begin
    hits_d    = hits_q;
    misses_d  = misses_q;
    probes_d  = probes_q;
    probe_sum = {1'b0, probes_q} + {{(33-PCNT_W){1'b0}}, probe_cnt};
    if (rsp_fire) begin
      if (rsp_hit) begin
        if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
      end else begin
        if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
      end
      probes_d = probe_sum[32] ? 32'hFFFF_FFFF : probe_sum[31:0];
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hits_q   <= '0;
      misses_q <= '0;
      probes_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      probes_q <= probes_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_probes = probes_q;

endmodule

// File: rtl/mac_hash_lookup.sv
// Linear-probe MAC hash table lookup against an external 1-cycle-latency RAM.
// Latency 1+2*probes cycles from accept to rsp_valid; one lookup in flight.
// Holds the response indefinitely while rsp_ready is low; optional LOOKUP_STATS_EN counters.
module mac_hash_lookup
  import mac_hash_lookup_pkg::*;
#(
  parameter int INDEX_W   = 8,
  parameter int PORT_W    = 8,
  parameter int MAX_PROBE = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  mac_hash_lookup_if.slave        bus
`ifdef LOOKUP_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_probes
`endif
);

  localparam int PCNT_W = $clog2(MAX_PROBE + 1);
  localparam logic [PCNT_W-1:0] LAST_PROBE = PCNT_W'(MAX_PROBE - 1);

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   idx_q, idx_d;
  logic [PCNT_W-1:0]    probes_q, probes_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 hit_q, hit_d;
  logic [PORT_W-1:0]    port_q, port_d;
  logic [INDEX_W-1:0]   slot_q, slot_d;

  logic                 ent_vld;
  logic [KEY_W-1:0]     ent_key;
  logic [PORT_W-1:0]    ent_port;
  logic                 unused_hash_hi;

  assign ent_vld  = bus.tbl_rd_data[valid_bit(PORT_W)];
  assign ent_key  = bus.tbl_rd_data[key_lsb(PORT_W) +: KEY_W];
  assign ent_port = bus.tbl_rd_data[PORT_W-1:0];

  // Only the low INDEX_W hash bits select the home slot.
  assign unused_hash_hi = ^bus.req_hash[31:INDEX_W];

  // Lookup FSM next state: read a slot, check it, step to the next slot or answer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    probes_d = probes_q;
    key_d    = key_q;
    hit_d    = hit_q;
    port_d   = port_q;
    slot_d   = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          key_d    = bus.req_key;
          idx_d    = bus.req_hash[INDEX_W-1:0];
          probes_d = '0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (ent_vld && (ent_key == key_q)) begin
          hit_d   = 1'b1;
          port_d  = ent_port;
          slot_d  = idx_q;
          state_d = ST_RESP;
        end else if (!ent_vld || (probes_q == LAST_PROBE)) begin
          // An empty slot ends the chain; otherwise the probe budget is spent.
          hit_d   = 1'b0;
          port_d  = '0;
          slot_d  = idx_q;
          state_d = ST_RESP;
        end else begin
          // Truncating add gives the wrap from the last slot back to slot 0.
          idx_d    = idx_q + 1'b1;
          probes_d = probes_q + 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any lookup in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      probes_q <= '0;
      key_q    <= '0;
      hit_q    <= 1'b0;
      port_q   <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      probes_q <= probes_d;
      key_q    <= key_d;
      hit_q    <= hit_d;
      port_q   <= port_d;
      slot_q   <= slot_d;
    end
  end

  // All outputs decode from registers only, so reset clears them asynchronously.
  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.tbl_rd_en   = (state_q == ST_READ);
  assign bus.tbl_rd_addr = idx_q;
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_hit     = hit_q;
  assign bus.rsp_port    = port_q;
  assign bus.rsp_slot    = slot_q;

`ifdef LOOKUP_STATS_EN
  logic              rsp_fire;
  logic [PCNT_W-1:0] probe_cnt;

  assign rsp_fire  = (state_q == ST_RESP) && bus.rsp_ready;
  // probes_q counts the extra slots after the home slot.
  assign probe_cnt = probes_q + 1'b1;

  mac_lookup_stats #(
    .PCNT_W (PCNT_W)
  ) u_stats (
    .clk         (clk),
    .resetn      (resetn),
    .rsp_fire    (rsp_fire),
    .rsp_hit     (hit_q),
    .probe_cnt   (probe_cnt),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_probes (stat_probes)
  );
`endif

endmodule

// File: tb/tb_mac_hash_lookup.sv
// Directed bench for mac_hash_lookup with a 1-cycle-latency table RAM model.
// Covers first-slot hit, collision chain, empty-slot miss, probe-limit wrap miss,
// backpressure, reset in READ, and the LOOKUP_STATS_EN counters when defined.
module tb_mac_hash_lookup;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  logic [56:0] mem [256];

  localparam logic [47:0] K1 = 48'h0011_2233_4455;
  localparam logic [47:0] KA = 48'h1111_1111_1111;
  localparam logic [47:0] KB = 48'h2222_2222_2222;
  localparam logic [47:0] K2 = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] KX = 48'hDEAD_BEEF_0001;

  mac_hash_lookup_if #(.INDEX_W(8), .PORT_W(8)) bus ();

`ifdef LOOKUP_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_probes;
`endif

  mac_hash_lookup #(
    .INDEX_W   (8),
    .PORT_W    (8),
    .MAX_PROBE (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
`ifdef LOOKUP_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_probes (stat_probes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read table RAM.
  always @(posedge clk) begin
    if (bus.tbl_rd_en) bus.tbl_rd_data <= mem[bus.tbl_rd_addr];
  end

  function automatic logic [56:0] ent(input logic v, input logic [47:0] k, input logic [7:0] p);
    return {v, k, p};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    check({tag, "_rd_en"},     {63'd0, bus.tbl_rd_en}, 64'd0);
    check({tag, "_rd_addr"},   {56'd0, bus.tbl_rd_addr}, 64'd0);
    check({tag, "_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    check({tag, "_rsp_hit"},   {63'd0, bus.rsp_hit}, 64'd0);
    check({tag, "_rsp_port"},  {56'd0, bus.rsp_port}, 64'd0);
    check({tag, "_rsp_slot"},  {56'd0, bus.rsp_slot}, 64'd0);
  endtask

  // Issue one request from an IDLE point (#1 after a clock edge) and check the response.
  task automatic lookup(input string tag, input logic [47:0] key, input logic [31:0] hash,
                        input logic exp_hit, input logic [7:0] exp_port,
                        input logic [7:0] exp_slot, input int exp_lat);
    int cyc;
    logic [7:0] home;
    home = hash[7:0];
    bus.req_valid = 1'b1;
    bus.req_key   = key;
    bus.req_hash  = hash;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check({tag, "_rd_en"},   {63'd0, bus.tbl_rd_en}, 64'd1);
    check({tag, "_rd_addr"}, {56'd0, bus.tbl_rd_addr}, {56'd0, home});
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_hit"},  {63'd0, bus.rsp_hit}, {63'd0, exp_hit});
    check({tag, "_port"}, {56'd0, bus.rsp_port}, {56'd0, exp_port});
    check({tag, "_slot"}, {56'd0, bus.rsp_slot}, {56'd0, exp_slot});
    if (bus.rsp_ready === 1'b1) begin
      @(posedge clk);
      #1;
      check({tag, "_rsp_drop"}, {63'd0, bus.rsp_valid}, 64'd0);
      check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_hash  = '0;
    bus.rsp_ready = 1'b1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // First-slot hit; upper hash bits must be ignored.
    mem[8'h12] = ent(1'b1, K1, 8'h04);
    lookup("first_hit", K1, 32'h0000_0012, 1'b1, 8'h04, 8'h12, 3);
    lookup("hash_hi_ignored", K1, 32'hABCD_EF12, 1'b1, 8'h04, 8'h12, 3);

    // Collision chain: key sits two slots past home.
    mem[8'h12] = ent(1'b1, KA, 8'h01);
    mem[8'h13] = ent(1'b1, KB, 8'h09);
    mem[8'h14] = ent(1'b1, K2, 8'h07);
    lookup("chain_hit", K2, 32'hFFFF_FF12, 1'b1, 8'h07, 8'h14, 7);

    // Empty slot ends the chain even if the stored key matches.
    mem[8'h12] = ent(1'b0, K1, 8'h55);
    lookup("empty_miss", K1, 32'h0000_0012, 1'b0, 8'h00, 8'h12, 3);

    // Probe limit with wrap; the key in the fifth slot must not be found.
    mem[8'hFE] = ent(1'b1, KA, 8'h11);
    mem[8'hFF] = ent(1'b1, KB, 8'h22);
    mem[8'h00] = ent(1'b1, KX, 8'h33);
    mem[8'h01] = ent(1'b1, KA, 8'h44);
    mem[8'h02] = ent(1'b1, K2, 8'h66);
    lookup("wrap_miss", K2, 32'h0000_00FE, 1'b0, 8'h00, 8'h01, 9);

    // Backpressure: response held for 10 cycles with no reads and no accept.
    mem[8'h12] = ent(1'b1, K1, 8'h04);
    bus.rsp_ready = 1'b0;
    lookup("bp", K1, 32'h0000_0012, 1'b1, 8'h04, 8'h12, 3);
    bus.req_valid = 1'b1;
    bus.req_key   = KA;
    bus.req_hash  = 32'h0000_0030;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("bp_stable", {47'd0, bus.rsp_hit, bus.rsp_port, bus.rsp_slot}, {47'd0, 1'b1, 8'h04, 8'h12});
      check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
      check("bp_rd_en", {63'd0, bus.tbl_rd_en}, 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {63'd0, bus.rsp_valid}, 64'd0);

    // Reset asserted while in READ aborts the lookup.
    bus.req_valid = 1'b1;
    bus.req_key   = K1;
    bus.req_hash  = 32'h0000_0012;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rst_in_read", {63'd0, bus.tbl_rd_en}, 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
`ifdef LOOKUP_STATS_EN
    check("stat_hits_reset",   {32'd0, stat_hits},   64'd0);
    check("stat_misses_reset", {32'd0, stat_misses}, 64'd0);
    check("stat_probes_reset", {32'd0, stat_probes}, 64'd0);
`endif

    // After reset: 3 hits (1+3+2 probes) and 2 misses (1+2 probes) = 9 probes.
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h12] = ent(1'b1, K1, 8'h04);
    lookup("post_rst_hit", K1, 32'h0000_0012, 1'b1, 8'h04, 8'h12, 3);
    mem[8'h12] = ent(1'b1, KA, 8'h01);
    mem[8'h13] = ent(1'b1, KB, 8'h09);
    mem[8'h14] = ent(1'b1, K2, 8'h07);
    lookup("s_chain3", K2, 32'h0000_0012, 1'b1, 8'h07, 8'h14, 7);
    lookup("s_chain2", KB, 32'h0000_0012, 1'b1, 8'h09, 8'h13, 5);
    lookup("s_miss1", KX, 32'h0000_0020, 1'b0, 8'h00, 8'h20, 3);
    lookup("s_miss2", KX, 32'h0000_0014, 1'b0, 8'h00, 8'h15, 5);
`ifdef LOOKUP_STATS_EN
    check("stat_hits",   {32'd0, stat_hits},   64'd3);
    check("stat_misses", {32'd0, stat_misses}, 64'd2);
    check("stat_probes", {32'd0, stat_probes}, 64'd9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
